instr_mem_ctrl: RTL and testbench

Parametrised instruction memory for the RV32I fetch stage, successor to the single-cycle strobe/ack instruction ROM. Takes a full 32-bit byte PC and supports configurable wait states to emulate slower memory. Adds misaligned and out-of-range fault reporting, a flush that aborts an in-flight fetch, and a write-side load port for program download. Sits between the IF-stage PC register and the IF/ID pipeline register.

---
 rtl/instr_mem_ctrl_pkg.sv | 25 ++
 rtl/instr_mem_ctrl_imem_array.sv | 36 +++
 rtl/instr_mem_ctrl.sv | 134 +++++++++++++
 tb/tb_instr_mem_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_ctrl_pkg.sv
// Shared definitions for the RV32I fetch-stage instruction memory:
// controller state encoding, default fault instruction and address helpers.
package instr_mem_ctrl_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } state_e;

    // addi x0, x0, 0 -- harmless filler returned with a fault ack.
    localparam logic [31:0] NopWordDefault = 32'h0000_0013;

    localparam int unsigned CntW = 4;

    // Number of byte-offset bits inside one instruction word.
    function automatic int unsigned ofs_w(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    // Width of a word index into a memory of the given depth.
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/instr_mem_ctrl_imem_array.sv
// Instruction word array: one registered read port and one write port.
// Read-first: a read and write of the same word on one edge returns the old word.
// Ports:
//   i_clk                           clock
//   i_rd_en, i_rd_addr, o_rd_data   registered read (data holds until next read)
//   i_wr_en, i_wr_addr, i_wr_data   synchronous write
module instr_mem_ctrl_imem_array #(
    parameter int unsigned DEPTH     = 8192,
    parameter int unsigned DATA_W    = 32,
    parameter string       INIT_FILE = "",
    parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rd_en,
    input  logic [IDX_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            rd_data_q <= mem_q[i_rd_addr];
        end
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Fetch-stage instruction memory controller with configurable wait states,
// misaligned/out-of-range fault reporting, flush, and a program load port.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_stb, i_addr         fetch request with byte PC (ignored while o_busy)
//   i_flush               abort in-flight fetch and drop this cycle's request
//   o_busy                fetch waiting on wait states
//   o_ack, o_instr, o_err one-cycle ack; instr/err held until next ack
//   i_ld_en/addr/data     word write into the array
module instr_mem_ctrl
    import instr_mem_ctrl_pkg::*;
#(
    parameter int unsigned         MEMORY_DEPTH = 8192,
    parameter int unsigned         DATA_W       = 32,
    parameter int unsigned         WAIT_STATES  = 0,
    parameter string               INIT_FILE    = "",
    parameter logic [DATA_W-1:0]   NOP_WORD     = DATA_W'(NopWordDefault)
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_stb,
    input  logic [31:0]                     i_addr,
    input  logic                            i_flush,
    output logic                            o_busy,
    output logic                            o_ack,
    output logic [DATA_W-1:0]               o_instr,
    output logic                            o_err,
    input  logic                            i_ld_en,
    input  logic [$clog2(MEMORY_DEPTH)-1:0] i_ld_addr,
    input  logic [DATA_W-1:0]               i_ld_data
);

    localparam int unsigned OfsW = ofs_w(DATA_W);
    localparam int unsigned IdxW = idx_w(MEMORY_DEPTH);

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              ack_q;
    logic              fault_q;
    logic [DATA_W-1:0] instr_q;
    logic              err_q;

    logic [31:0]       word_idx;
    logic              misaligned;
    logic              out_of_range;
    logic              fault;
    logic              busy;
    logic              accept;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] instr_now;

    assign word_idx = i_addr >> OfsW;

    if (OfsW > 0) begin : g_align
        assign misaligned = |i_addr[OfsW-1:0];
    end else begin : g_no_align
        assign misaligned = 1'b0;
    end

    assign out_of_range = (word_idx >= 32'(MEMORY_DEPTH));
    assign fault        = misaligned | out_of_range;
    assign busy         = (state_q == StWait);
    assign accept       = i_stb & ~busy & ~i_flush;

    instr_mem_ctrl_imem_array #(
        .DEPTH     (MEMORY_DEPTH),
        .DATA_W    (DATA_W),
        .INIT_FILE (INIT_FILE),
        .IDX_W     (IdxW)
    ) u_array (
        .i_clk     (i_clk),
        .i_rd_en   (accept & ~fault & i_rst_n),
        .i_rd_addr (word_idx[IdxW-1:0]),
        .o_rd_data (rd_data),
        .i_wr_en   (i_ld_en),
        .i_wr_addr (i_ld_addr),
        .i_wr_data (i_ld_data)
    );

    // The array output register is the holding register for the pending word;
    // it is only reloaded on accept, which cannot happen while waiting.
    assign instr_now = fault_q ? NOP_WORD : rd_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            fault_q <= 1'b0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // Latch the presented result so it holds after the ack pulse.
            if (ack_q) begin
                instr_q <= instr_now;
                err_q   <= fault_q;
            end
            if (i_flush) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                ack_q   <= 1'b0;
            end else begin
                ack_q <= 1'b0;
                unique case (state_q)
                    StIdle: begin
                        if (accept) begin
                            fault_q <= fault;
                            if (WAIT_STATES == 0) begin
                                ack_q <= 1'b1;
                            end else begin
                                state_q <= StWait;
                                cnt_q   <= CntW'(WAIT_STATES);
                            end
                        end
                    end
                    StWait: begin
                        cnt_q <= cnt_q - CntW'(1);
                        if (cnt_q == CntW'(1)) begin
                            state_q <= StIdle;
                            ack_q   <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign o_busy  = busy;
    assign o_ack   = ack_q;
    assign o_instr = ack_q ? instr_now : instr_q;
    assign o_err   = ack_q ? fault_q : err_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Three instances (0, 2 and 3 wait states) share one stimulus stream; each is
// compared every cycle against a due-edge scheduling model, plus literal checks.
module tb_instr_mem_ctrl;

    localparam int unsigned Depth = 64;
    localparam int          NDut  = 3;
    localparam logic [31:0] Nop   = 32'h0000_0013;
    localparam logic [31:0] Base  = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst_n, stb, flush, ld_en;
    logic [31:0] addr, ld_data;
    logic [5:0]  ld_addr;

    logic        d_busy [NDut];
    logic        d_ack  [NDut];
    logic        d_err  [NDut];
    logic [31:0] d_instr[NDut];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDut; g++) begin : g_dut
        instr_mem_ctrl #(
            .MEMORY_DEPTH (Depth),
            .DATA_W       (32),
            .WAIT_STATES  ((g == 0) ? 0 : g + 1),
            .INIT_FILE    (""),
            .NOP_WORD     (Nop)
        ) u_dut (
            .i_clk     (clk),
            .i_rst_n   (rst_n),
            .i_stb     (stb),
            .i_addr    (addr),
            .i_flush   (flush),
            .o_busy    (d_busy[g]),
            .o_ack     (d_ack[g]),
            .o_instr   (d_instr[g]),
            .o_err     (d_err[g]),
            .i_ld_en   (ld_en),
            .i_ld_addr (ld_addr),
            .i_ld_data (ld_data)
        );
    end

    function automatic int ws(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem   [Depth];
    bit          m_pend  [NDut];
    int          m_due   [NDut];
    logic [31:0] m_pinstr[NDut];
    bit          m_perr  [NDut];
    bit          x_ack   [NDut];
    bit          x_busy  [NDut];
    bit          x_err   [NDut];
    logic [31:0] x_instr [NDut];
    int          edge_n  = 0;
    bit          started = 0;

    always @(posedge clk) begin
        logic [31:0] widx;
        bit          flt;
        widx = addr >> 2;
        flt  = (addr[1:0] != 2'b00) || (widx >= Depth);
        for (int k = 0; k < NDut; k++) begin
            if (!rst_n) begin
                m_pend[k]  = 0;
                x_ack[k]   = 0;
                x_busy[k]  = 0;
                x_err[k]   = 0;
                x_instr[k] = '0;
            end else if (flush) begin
                m_pend[k] = 0;
                x_ack[k]  = 0;
                x_busy[k] = 0;
            end else begin
                x_ack[k] = 0;
                if (m_pend[k] && m_due[k] == edge_n) begin
                    x_ack[k]   = 1;
                    x_instr[k] = m_pinstr[k];
                    x_err[k]   = m_perr[k];
                    m_pend[k]  = 0;
                end
                if (stb && !x_busy[k]) begin
                    m_pinstr[k] = flt ? Nop : m_mem[widx[5:0]];
                    m_perr[k]   = flt;
                    if (ws(k) == 0) begin
                        x_ack[k]   = 1;
                        x_instr[k] = m_pinstr[k];
                        x_err[k]   = m_perr[k];
                    end else begin
                        m_pend[k] = 1;
                        m_due[k]  = edge_n + ws(k);
                    end
                end
                x_busy[k] = m_pend[k];
            end
        end
        if (ld_en) m_mem[ld_addr] = ld_data;
        edge_n++;
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < NDut; k++) begin
                chk($sformatf("m%0d_ack", k),   32'(d_ack[k]),  32'(x_ack[k]));
                chk($sformatf("m%0d_busy", k),  32'(d_busy[k]), 32'(x_busy[k]));
                chk($sformatf("m%0d_err", k),   32'(d_err[k]),  32'(x_err[k]));
                chk($sformatf("m%0d_instr", k), d_instr[k],     x_instr[k]);
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stb = 1'b0; flush = 1'b0; ld_en = 1'b0;
        addr = '0; ld_addr = '0; ld_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_instr", d_instr[0], 32'h0);
        chk("rst_busy3", 32'(d_busy[2]), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < int'(Depth); i++) begin
            ld_en = 1'b1; ld_addr = 6'(i); ld_data = Base + 32'(i);
            tick();
        end
        ld_en = 1'b0;

        // Zero wait states: one ack per cycle.
        for (int n = 0; n < 4; n++) begin
            stb = 1'b1; addr = 32'(4 * n);
            tick();
            chk("w0_ack",   32'(d_ack[0]),  32'h1);
            chk("w0_busy",  32'(d_busy[0]), 32'h0);
            chk("w0_instr", d_instr[0],     Base + 32'(n));
        end
        stb = 1'b0;
        repeat (6) tick();

        // Three wait states, stb held while busy.
        stb = 1'b1; addr = 32'h10;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("w3_busy", 32'(d_busy[2]), 32'h1);
            chk("w3_noack", 32'(d_ack[2]), 32'h0);
        end
        stb = 1'b0;
        tick();
        chk("w3_ack",   32'(d_ack[2]),  32'h1);
        chk("w3_instr", d_instr[2],     Base + 32'h4);
        tick();
        chk("w3_single", 32'(d_ack[2]), 32'h0);
        repeat (6) tick();

        // Faults.
        stb = 1'b1; addr = 32'h6;
        tick();
        stb = 1'b0;
        chk("mis_err",   32'(d_err[0]), 32'h1);
        chk("mis_instr", d_instr[0],    Nop);
        repeat (5) tick();
        stb = 1'b1; addr = 32'(4 * Depth);
        tick();
        stb = 1'b0;
        chk("oor_ack", 32'(d_ack[0]), 32'h1);
        chk("oor_err", 32'(d_err[0]), 32'h1);
        repeat (5) tick();

        // Flush on the ack-producing edge of the 2-wait instance.
        stb = 1'b1; addr = 32'h20;
        tick();
        stb = 1'b0;
        tick();
        chk("fl_busy_pre", 32'(d_busy[1]), 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_noack", 32'(d_ack[1]),  32'h0);
        chk("fl_busy",  32'(d_busy[1]), 32'h0);
        chk("fl_instr", d_instr[1],     Nop);
        tick();
        chk("fl_late", 32'(d_ack[1]), 32'h0);
        stb = 1'b1; addr = 32'h24;
        tick();
        stb = 1'b0;
        tick();
        tick();
        chk("fl_next_ack",   32'(d_ack[1]), 32'h1);
        chk("fl_next_instr", d_instr[1],    Base + 32'h9);
        chk("fl_next_err",   32'(d_err[1]), 32'h0);
        repeat (5) tick();

        // Load and fetch of the same word on one edge: old data first.
        ld_en = 1'b1; ld_addr = 6'd5; ld_data = 32'hDEAD_BEEF;
        stb = 1'b1; addr = 32'h14;
        tick();
        ld_en = 1'b0; stb = 1'b0;
        chk("ld_old", d_instr[0], Base + 32'h5);
        repeat (5) tick();
        stb = 1'b1; addr = 32'h14;
        tick();
        stb = 1'b0;
        chk("ld_new", d_instr[0], 32'hDEAD_BEEF);
        repeat (5) tick();

        // Reset while waiting.
        stb = 1'b1; addr = 32'h0;
        tick();
        stb = 1'b0;
        tick();
        chk("rw_busy_pre", 32'(d_busy[2]), 32'h1);
        rst_n = 1'b0;
        tick();
        chk("rw_busy",  32'(d_busy[2]), 32'h0);
        chk("rw_ack",   32'(d_ack[2]),  32'h0);
        chk("rw_err",   32'(d_err[2]),  32'h0);
        chk("rw_instr", d_instr[2],     32'h0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            rst_n   = ($urandom_range(0, 99) != 0);
            flush   = ($urandom_range(0, 19) == 0);
            stb     = 1'($urandom_range(0, 1));
            ld_en   = ($urandom_range(0, 9) == 0);
            ld_addr = 6'($urandom);
            ld_data = $urandom;
            sel     = int'($urandom_range(0, 9));
            if (sel == 0)      addr = $urandom;
            else if (sel == 1) addr = 32'($urandom_range(Depth, 4 * Depth)) << 2;
            else               addr = 32'($urandom_range(0, Depth - 1)) << 2;
            tick();
        end
        rst_n = 1'b1; flush = 1'b0; stb = 1'b0; ld_en = 1'b0;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
